// File: rtl/oam_dma.sv
// Sprite DMA engine: a write of page P to $4014 halts the CPU and copies
// $PP00-$PPFF to $2004, one read/write pair per byte.
module oam_dma (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_rw,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_rw,
   input  logic [7:0]  bus_rdata,
   output logic        dma_active
);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

   state_t      r_state;
   state_t      w_next;
   logic        r_cyc_odd;
   logic [7:0]  r_page;
   logic [7:0]  r_idx;
   logic [7:0]  r_data;
   logic        w_trigger;

   assign w_trigger = (r_state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cyc_odd <= 1'b0;
         r_page    <= 8'h00;
         r_idx     <= 8'h00;
         r_data    <= 8'h00;
      end else begin
         r_state   <= w_next;
         r_cyc_odd <= ~r_cyc_odd;
         if (w_trigger) begin
            r_page <= cpu_wdata;
            r_idx  <= 8'h00;
         end
         if (r_state == READ) begin
            r_data <= bus_rdata;
         end
         // idx wraps within its own 8 bits; the page never advances.
         if ((r_state == WRITE) && (r_idx != 8'hFF)) begin
            r_idx <= r_idx + 8'd1;
         end
      end
   end

   // NOTE: every output and w_next gets a default first, so no path through
   // the case statement can infer a latch.
   always_comb begin
      w_next     = r_state;
      cpu_rdy    = 1'b0;
      dma_active = 1'b1;
      bus_addr   = cpu_addr;
      bus_wdata  = cpu_wdata;
      bus_rw     = 1'b1;

      unique case (r_state)
         IDLE: begin
            cpu_rdy    = 1'b1;
            dma_active = 1'b0;
            bus_rw     = cpu_rw;
            if (w_trigger) begin
               w_next = HALT;
            end
         end
         HALT: begin
            w_next = r_cyc_odd ? ALIGN : READ;
         end
         ALIGN: begin
            w_next = READ;
         end
         READ: begin
            bus_addr  = {r_page, r_idx};
            bus_wdata = r_data;
            w_next    = WRITE;
         end
         WRITE: begin
            bus_addr  = OAM_DATA_ADDR;
            bus_wdata = r_data;
            bus_rw    = 1'b0;
            w_next    = (r_idx == 8'hFF) ? IDLE : READ;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a scoreboard of expected {read address,
// data} pairs is filled at each trigger and drained on every $2004 write.
module tb_oam_dma;

   logic        clock;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rw;
   logic        cpu_rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_rw;
   logic [7:0]  bus_rdata;
   logic        dma_active;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t q[$];
   int   n_pass;
   int   n_total;
   int   exp_stall;
   logic m_odd;

   oam_dma dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rw     (cpu_rw),
      .cpu_rdy    (cpu_rdy),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rw     (bus_rw),
      .bus_rdata  (bus_rdata),
      .dma_active (dma_active)
   );

   // Memory image: page $02 holds idx ^ $5A; other pages are distinct too.
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h58;
   endfunction

   assign bus_rdata = mem_f(bus_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference parity: cleared by reset, toggles on every other edge.
   always @(posedge clock) m_odd <= reset ? 1'b0 : ~m_odd;

   task automatic set_idle();
      cpu_rw    = 1'b1;
      cpu_addr  = 16'h1234;
      cpu_wdata = 8'h00;
   endtask

   // Returns at posedge+1 in a cycle whose parity gives the wanted HALT alignment.
   task automatic align_for(input bit want_align);
      logic want;
      want = want_align ? 1'b0 : 1'b1;
      @(posedge clock); #1;
      while (m_odd !== want) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic start_dma(input logic [7:0] page);
      exp_stall = (m_odd == 1'b0) ? 514 : 513;
      for (int i = 0; i < 256; i++) begin
         q.push_back({{page, 8'(i)}, mem_f({page, 8'(i)})});
      end
      cpu_rw    = 1'b0;
      cpu_addr  = 16'h4014;
      cpu_wdata = page;
      @(posedge clock); #1;
      set_idle();
   endtask

   // Watches one transfer until cpu_rdy returns. kind 1 re-triggers after
   // inject_at writes; kind 2 pulses reset in the READ following inject_at writes.
   task automatic run_dma(input int inject_at, input int kind,
                          output int stall, output int nwr);
      logic [15:0] prev_addr;
      exp_t        e;
      int          cyc;
      int          hold;
      bit          done;
      bit          armed;
      bit          injected;
      stall = 0; nwr = 0; cyc = 0; hold = 0;
      done = 0; armed = 0; injected = 0;
      prev_addr = 16'h0000;
      while (!done && cyc < 700) begin
         @(negedge clock);
         cyc++;
         if (cpu_rdy === 1'b1) begin
            done = 1;
         end else begin
            stall++;
            if (hold > 0) begin
               hold--;
               if (hold == 0) set_idle();
            end
            if (bus_rw === 1'b0 && bus_addr === 16'h2004) begin
               nwr++;
               if (q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_write: data %02h, none expected", bus_wdata);
               end else begin
                  e = q.pop_front();
                  n_total++;
                  if (prev_addr !== e.addr)
                     $display("FAIL read_addr[%0d]: got %04h expected %04h", nwr, prev_addr, e.addr);
                  else n_pass++;
                  n_total++;
                  if (bus_wdata !== e.data)
                     $display("FAIL write_data[%0d]: got %02h expected %02h", nwr, bus_wdata, e.data);
                  else n_pass++;
               end
               if (nwr == inject_at && !injected) begin
                  injected = 1;
                  if (kind == 1) begin
                     cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'hEE;
                     hold = 3;
                  end else if (kind == 2) begin
                     armed = 1;
                  end
               end
            end else if (armed) begin
               armed = 0;
               reset = 1'b1;
            end
            prev_addr = bus_addr;
         end
      end
      n_total++;
      if (!done) $display("FAIL dma_timeout: cpu_rdy still %b after %0d cycles", cpu_rdy, cyc);
      else n_pass++;
   endtask

   task automatic check_passthrough(input string name);
      n_total++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || bus_addr !== cpu_addr ||
          bus_rw !== cpu_rw || bus_wdata !== cpu_wdata)
         $display("FAIL %s: rdy=%b act=%b addr=%04h rw=%b wd=%02h expected rdy=1 act=0 addr=%04h rw=%b wd=%02h",
                  name, cpu_rdy, dma_active, bus_addr, bus_rw, bus_wdata, cpu_addr, cpu_rw, cpu_wdata);
      else n_pass++;
   endtask

   task automatic check_done(input string name, input int stall, input int want_stall, input int nwr);
      n_total++;
      if (stall !== want_stall) $display("FAIL %s_stall: got %0d expected %0d", name, stall, want_stall);
      else n_pass++;
      n_total++;
      if (nwr !== 256) $display("FAIL %s_writes: got %0d expected 256", name, nwr);
      else n_pass++;
      n_total++;
      if (q.size() != 0) $display("FAIL %s_leftover: got %0d expected 0", name, q.size());
      else n_pass++;
      q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'hEE;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_passthrough("reset_state");
      reset = 1'b0;
      set_idle();
      @(negedge clock);
      check_passthrough("reset_no_trigger");
   endtask

   task automatic test_even();
      int stall, nwr;
      align_for(1'b0);
      start_dma(8'h02);
      run_dma(-1, 0, stall, nwr);
      check_done("even", stall, 513, nwr);
      check_passthrough("even_restore");
   endtask

   task automatic test_odd();
      int stall, nwr;
      align_for(1'b1);
      start_dma(8'h02);
      run_dma(-1, 0, stall, nwr);
      check_done("odd", stall, 514, nwr);
      check_passthrough("odd_restore");
   endtask

   task automatic test_page_wrap();
      int stall, nwr;
      align_for(1'b0);
      start_dma(8'hFF);
      run_dma(-1, 0, stall, nwr);
      check_done("wrap", stall, 513, nwr);
      check_passthrough("wrap_restore");
   endtask

   task automatic test_retrigger();
      int stall, nwr;
      align_for(1'b0);
      start_dma(8'h10);
      run_dma(64, 1, stall, nwr);
      check_done("retrig", stall, 513, nwr);
   endtask

   task automatic test_back_to_back();
      int stall, nwr;
      align_for(1'b0);
      start_dma(8'h30);
      run_dma(-1, 0, stall, nwr);
      check_done("b2b_first", stall, 513, nwr);
      start_dma(8'h31);
      run_dma(-1, 0, stall, nwr);
      check_done("b2b_second", stall, exp_stall, nwr);
      check_passthrough("b2b_restore");
   endtask

   task automatic test_reset_mid();
      int stall, nwr, extra;
      align_for(1'b0);
      start_dma(8'h05);
      run_dma(128, 2, stall, nwr);
      n_total++;
      if (nwr !== 128) $display("FAIL rstmid_writes: got %0d expected 128", nwr);
      else n_pass++;
      check_passthrough("rstmid_restore");
      reset = 1'b0;
      q.delete();
      extra = 0;
      repeat (20) begin
         @(negedge clock);
         if ((bus_rw === 1'b0 && bus_addr === 16'h2004) || dma_active !== 1'b0) extra++;
      end
      n_total++;
      if (extra !== 0) $display("FAIL rstmid_quiet: got %0d dma cycles expected 0", extra);
      else n_pass++;
   endtask

   task automatic test_non_trigger();
      logic [15:0] addrs [3];
      logic        rws   [3];
      addrs[0] = 16'h4014; rws[0] = 1'b1;
      addrs[1] = 16'h4015; rws[1] = 1'b0;
      addrs[2] = 16'h2014; rws[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         cpu_addr = addrs[i]; cpu_rw = rws[i]; cpu_wdata = 8'h02;
         @(negedge clock);
         check_passthrough($sformatf("nontrig_pass_%04h", addrs[i]));
         @(posedge clock); #1;
         set_idle();
         @(negedge clock);
         check_passthrough($sformatf("nontrig_after_%04h", addrs[i]));
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      exp_stall = 0;
      reset = 1'b1;
      set_idle();
      test_reset();
      test_non_trigger();
      test_even();
      test_odd();
      test_page_wrap();
      test_retrigger();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port cpu_addr  input  16  CPU address output.
REQ-004 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-005 SHALL have port cpu_rw  input  1  CPU direction: 1 = read, 0 = write.
REQ-006 SHALL have port cpu_rdy  output  1  CPU ready; 0 stalls the CPU.
REQ-007 SHALL have port bus_addr  output  16  system bus address.
REQ-008 SHALL have port bus_wdata  output  8  system bus write data.
REQ-009 SHALL have port bus_rw  output  1  system bus direction: 1 = read, 0 = write.
REQ-010 SHALL have port bus_rdata  input  8  memory read data; valid at the rising edge ending the address cycle.
REQ-011 SHALL have port dma_active  output  1  high while DMA owns the bus.
REQ-012 SHALL use a single clock domain (clock), with a synchronous active-high reset.

Function
REQ-013 SHALL have states IDLE, HALT, ALIGN, READ and WRITE.
REQ-014 SHALL keep a free-running parity bit cyc_odd that toggles every clock.
REQ-015 SHALL, in IDLE, pass the CPU straight through: bus_addr=cpu_addr, bus_wdata=cpu_wdata, bus_rw=cpu_rw, cpu_rdy=1, dma_active=0.
REQ-016 SHALL trigger on an IDLE cycle with cpu_rw=0 and cpu_addr=16'h4014: latch page=cpu_wdata and idx=0, then go to HALT.
REQ-017 SHALL pass the trigger write itself to the bus unchanged.
REQ-018 SHALL, in HALT, drive cpu_rdy=0, dma_active=1, bus_rw=1 and bus_addr=cpu_addr (dummy read).
REQ-019 SHALL leave HALT for ALIGN if cyc_odd=1 during HALT, otherwise for READ.
REQ-020 SHALL, in ALIGN, behave as HALT for exactly one cycle, then go to READ.
REQ-021 SHALL, in READ, drive bus_addr={page,idx} and bus_rw=1, capture bus_rdata into a data register at the closing edge, then go to WRITE.
REQ-022 SHALL, in WRITE, drive bus_addr=16'h2004, bus_rw=0 and bus_wdata=the data register.
REQ-023 SHALL, at the end of WRITE: if idx=8'hFF go to IDLE, else increment idx and go to READ.
REQ-024 SHALL keep idx at 8 bits and SHALL NOT carry into page.
REQ-025 SHALL hold cpu_rdy=0 and dma_active=1 in every state except IDLE.
REQ-026 SHALL stall for 513 cycles when no ALIGN is taken and 514 cycles when ALIGN is taken, counted from the cycle after the trigger.
REQ-027 SHALL ignore CPU bus inputs, including any further $4014 write, while not in IDLE.
REQ-028 SHALL restore CPU pass-through in the first cycle after WRITE of idx=FF.
REQ-029 SHALL allow a trigger to be accepted in that same first IDLE cycle.
REQ-030 SHALL NOT trigger on a CPU read of $4014.
REQ-031 SHALL NOT trigger on a write to any other address, including $4015 and $2014.

Reset
REQ-032 SHALL, while reset=1 at a rising edge, force state=IDLE, idx=0, page=0, data register=0 and cyc_odd=0.
REQ-033 SHALL, in the cycle after a reset edge, present cpu_rdy=1, dma_active=0 and pass-through bus outputs.
REQ-034 SHALL apply REQ-032/REQ-033 when reset arrives mid-transfer: abort immediately, with no further $2004 writes.
REQ-035 SHALL NOT trigger on a $4014 write coincident with reset.

Verification
REQ-036 Even-aligned trigger: memory $0200-$02FF=idx^8'h5A; CPU writes $02 to $4014 with HALT on an even cycle -> exactly 256 writes to $2004 with data $5A,$5B,...,$A5; cpu_rdy low for 513 cycles.
REQ-037 Odd-aligned trigger: same stimulus shifted one cycle -> ALIGN visited once, cpu_rdy low for 514 cycles, same data sequence.
REQ-038 Page wrap: trigger with $FF -> reads $FF00-$FFFF, last read at $FFFF, no access at $0000, then return to IDLE.
REQ-039 Re-trigger ignored: CPU writes $4014 at idx=$40 (forced pass) -> page unchanged, transfer completes normally; back-to-back trigger in the first IDLE cycle starts a new transfer.
REQ-040 Reset mid-transfer: assert reset at idx=$80 for 1 cycle -> next cycle cpu_rdy=1, dma_active=0, bus_addr=cpu_addr; no further $2004 writes.
REQ-041 Non-trigger accesses: read $4014, write $4015, write $2014 -> no state change, cpu_rdy stays 1.
